key_counter_4b: RTL and testbench

//  Upstream source for the 4-bit BCD/7-segment display decoder. Debounces three active-low board

---
 rtl/key_counter_pkg.sv | 24 ++
 rtl/key_debouncer.sv | 116 +++++++++++
 rtl/key_counter_4b.sv | 122 ++++++++++++
 tb/tb_key_counter_4b.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/key_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_counter_pkg
// Description : Shared types and constants for the key_counter_4b block.
//               Holds the debouncer state encoding, the count width and type,
//               and the load clamp helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package key_counter_pkg;

  typedef enum logic [1:0] {REL, P_CHK, PRS, R_CHK} deb_state_t;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] count_t;

  // A load value above the top count is pinned to the top count.
  function automatic count_t clamp_load(input count_t val, input count_t max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage : key_counter_pkg
`default_nettype wire

// File: rtl/key_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : 2-FF synchronizer plus debounce FSM for one active-low key.
//               Emits a one-cycle press_pulse per accepted press.
// Ports       : clk         - system clock
//               rst         - synchronous reset, active-high
//               key_n       - raw active-low key, asynchronous to clk
//               press_pulse - one-cycle pulse when a press is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press_pulse
);

  import key_counter_pkg::*;

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_limit = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] c_one   = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic [1:0]    prime_q;
  logic          armed_q, armed_d;
  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;
  logic          pressed;

  assign pressed     = ~sync2_q;
  assign press_pulse = pulse_q;

  // prime_q marks when sync2_q holds a genuine pin sample rather than its
  // reset value. The FSM is only armed after it has seen a real released
  // sample, so a key held through reset must be released before it counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prime_q <= 2'b00;
      armed_q <= 1'b0;
      state_q <= REL;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      prime_q <= {prime_q[0], 1'b1};
      armed_q <= armed_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    armed_d = armed_q;
    case (state_q)
      REL: begin
        if (prime_q[1] && !pressed) begin
          armed_d = 1'b1;
        end
        if (armed_q && pressed) begin
          state_d = P_CHK;
          cnt_d   = c_one;
        end
      end
      P_CHK: begin
        if (pressed) begin
          if (cnt_q == c_limit) begin
            state_d = PRS;
            pulse_d = 1'b1;
          end else begin
            cnt_d = cnt_q + c_one;
          end
        end else begin
          state_d = REL;
          cnt_d   = '0;
        end
      end
      PRS: begin
        if (!pressed) begin
          state_d = R_CHK;
          cnt_d   = c_one;
        end
      end
      R_CHK: begin
        if (!pressed) begin
          if (cnt_q == c_limit) begin
            state_d = REL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + c_one;
          end
        end else begin
          state_d = PRS;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

endmodule : key_debouncer
`default_nettype wire

// File: rtl/key_counter_4b.sv
`default_nettype none
// ============================================================================
// Module      : key_counter_4b
// Description : Debounces increment/decrement/load keys and maintains a
//               4-bit count for the 7-segment decoder, with update and
//               bound flags.
//               Build option KEY_COUNTER_SATURATE_EN: when defined the count
//               saturates at 0 and CNT_MAX; otherwise it wraps.
// Ports       : clk       - system clock, 50 MHz
//               rst       - synchronous reset, active-high
//               key_inc_n - increment key, active-low, asynchronous
//               key_dec_n - decrement key, active-low, asynchronous
//               key_ld_n  - load key, active-low, asynchronous
//               sw_val    - load value from slide switches
//               count     - current count
//               changed   - one-cycle pulse when count takes a new value
//               at_max    - count == CNT_MAX
//               at_min    - count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module key_counter_4b
  import key_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_MAX         = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_inc_n,
  input  logic             key_dec_n,
  input  logic             key_ld_n,
  input  logic [CNT_W-1:0] sw_val,
  output logic [CNT_W-1:0] count,
  output logic             changed,
  output logic             at_max,
  output logic             at_min
);

  localparam count_t c_cnt_max = count_t'(CNT_MAX);
  localparam count_t c_one     = count_t'(1);

  logic   inc_pulse;
  logic   dec_pulse;
  logic   ld_pulse;
  count_t sw_s1_q;
  count_t sw_s2_q;
  count_t count_q, count_d;
  logic   changed_q, changed_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_inc_n),
    .press_pulse (inc_pulse)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_dec_n),
    .press_pulse (dec_pulse)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ld (
    .clk         (clk),
    .rst         (rst),
    .key_n       (key_ld_n),
    .press_pulse (ld_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      count_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      sw_s1_q   <= sw_val;
      sw_s2_q   <= sw_s1_q;
      count_q   <= count_d;
      changed_q <= changed_d;
    end
  end

  // Load beats inc/dec; simultaneous inc and dec cancel out.
  always_comb begin
    count_d = count_q;
    if (ld_pulse) begin
      count_d = clamp_load(sw_s2_q, c_cnt_max);
    end else if (inc_pulse && dec_pulse) begin
      count_d = count_q;
    end else if (inc_pulse) begin
      if (count_q == c_cnt_max) begin
`ifdef KEY_COUNTER_SATURATE_EN
        count_d = c_cnt_max;
`else
        count_d = '0;
`endif
      end else begin
        count_d = count_q + c_one;
      end
    end else if (dec_pulse) begin
      if (count_q == '0) begin
`ifdef KEY_COUNTER_SATURATE_EN
        count_d = '0;
`else
        count_d = c_cnt_max;
`endif
      end else begin
        count_d = count_q - c_one;
      end
    end
    changed_d = (count_d != count_q);
  end

  assign count   = count_q;
  assign changed = changed_q;
  assign at_max  = (count_q == c_cnt_max);
  assign at_min  = (count_q == '0);

endmodule : key_counter_4b
`default_nettype wire

// File: tb/tb_key_counter_4b.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_counter_4b
// Description : Self-checking bench for key_counter_4b with randomized key
//               presses, bounces, loads and resets against a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_counter_4b;

  localparam int D    = 4;
  localparam int MAXV = 15;
`ifdef KEY_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_inc_n = 1'b1;
  logic       key_dec_n = 1'b1;
  logic       key_ld_n  = 1'b1;
  logic [3:0] sw_val    = 4'h0;
  logic [3:0] count;
  logic       changed;
  logic       at_max;
  logic       at_min;

  int checks = 0;
  int errors = 0;
  int model  = 0;
  int exp_q[$];
  int lat;

  always #5 clk = ~clk;

  key_counter_4b #(.DEBOUNCE_CYCLES(D), .CNT_MAX(MAXV)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_inc_n (key_inc_n),
    .key_dec_n (key_dec_n),
    .key_ld_n  (key_ld_n),
    .sw_val    (sw_val),
    .count     (count),
    .changed   (changed),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: what the count becomes after one accepted event.
  function automatic int next_val(input int c, input bit inc, input bit dec,
                                  input bit ld, input int sw);
    if (ld)          return (sw > MAXV) ? MAXV : sw;
    if (inc && dec)  return c;
    if (inc)         return (SAT && c == MAXV) ? MAXV : (c + 1) % (MAXV + 1);
    if (dec)         return (SAT && c == 0) ? 0 : (c + MAXV) % (MAXV + 1);
    return c;
  endfunction

  task automatic set_keys(input bit inc, input bit dec, input bit ld, input bit lvl);
    if (inc) key_inc_n = lvl;
    if (dec) key_dec_n = lvl;
    if (ld)  key_ld_n  = lvl;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"},  int'(count),  model);
    chk({tag, "_at_max"}, int'(at_max), int'(model == MAXV));
    chk({tag, "_at_min"}, int'(at_min), int'(model == 0));
  endtask

  // One press of the selected keys together, with optional short bounces
  // ahead of the stable low. lat = negedges from stable low to changed.
  task automatic do_press(input bit inc, input bit dec, input bit ld,
                          input int swv, input int bounces, output int lat_o);
    int nv;
    lat_o = -1;
    if (ld) begin
      sw_val = 4'(swv);
      repeat (3) @(negedge clk);
    end
    nv = next_val(model, inc, dec, ld, swv);
    if (nv != model) exp_q.push_back(nv);
    model = nv;
    for (int b = 0; b < bounces; b++) begin
      set_keys(inc, dec, ld, 1'b0);
      repeat ($urandom_range(1, 2)) @(negedge clk);
      set_keys(inc, dec, ld, 1'b1);
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    set_keys(inc, dec, ld, 1'b0);
    for (int i = 1; i <= D + 6; i++) begin
      @(negedge clk);
      if (changed === 1'b1 && lat_o < 0) lat_o = i;
    end
    set_keys(inc, dec, ld, 1'b1);
    repeat (D + 8) @(negedge clk);
    check_state("after_press");
  endtask

  // Scoreboard monitor: every changed pulse must match the next expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && changed === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_changed: actual count=%0d required no pulse at %0t",
                   count, $time);
        end else begin
          chk("changed_count", int'(count), exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int idle_pulses;
    // Reset and idle behaviour
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset");
    chk("reset_changed", int'(changed), 0);
    idle_pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (changed === 1'b1) idle_pulses++;
    end
    chk("idle_pulses", idle_pulses, 0);

    // Bounced increment, latency from stable low
    do_press(1'b1, 1'b0, 1'b0, 0, 3, lat);
    chk("inc_latency", lat, D + 3);

    // Top boundary
    do_press(1'b0, 1'b0, 1'b1, 15, 0, lat);
    do_press(1'b1, 1'b0, 1'b0, 0, 1, lat);

    // Cancel, then load 0xA
    do_press(1'b0, 1'b0, 1'b1, 5, 0, lat);
    do_press(1'b1, 1'b1, 1'b0, 0, 0, lat);
    do_press(1'b0, 1'b0, 1'b1, 10, 2, lat);
    do_press(1'b0, 1'b0, 1'b1, 10, 0, lat);

    // Reset while dec is mid-debounce and still held afterwards
    key_dec_n = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model = 0;
    repeat (3) @(negedge clk);
    check_state("mid_rst");
    do_press(1'b0, 1'b0, 1'b1, 7, 0, lat);
    repeat (20) @(negedge clk);
    chk("held_dec_after_rst", int'(count), 7);
    key_dec_n = 1'b1;
    repeat (D + 8) @(negedge clk);
    do_press(1'b0, 1'b1, 1'b0, 0, 1, lat);

    // Randomized operations
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 3))
        0: do_press(1'b1, 1'b0, 1'b0, 0, $urandom_range(0, 3), lat);
        1: do_press(1'b0, 1'b1, 1'b0, 0, $urandom_range(0, 3), lat);
        2: do_press(1'b0, 1'b0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 3), lat);
        default: do_press(1'b1, 1'b1, 1'b0, 0, $urandom_range(0, 3), lat);
      endcase
    end

    // Sixteen decrements from zero
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model = 0;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      do_press(1'b0, 1'b1, 1'b0, 0, $urandom_range(0, 2), lat);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_counter_4b
`default_nettype wire
